// File: rtl/relu_stream_ctrl.sv
// rtl/relu_stream_ctrl.sv - command-driven ReLU/bypass streamer for one activation vector
// One registered output stage; counts negative inputs and pulses done per vector.
module relu_stream_ctrl #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_bypass,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] neg_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;
  logic             bypass_q;
  logic             cmd_hs;
  logic             in_hs;
  logic             out_hs;
  logic             last_elem;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  // The output register can take a new element when empty or emptying this cycle.
  assign in_ready  = (state == RUN) && (!out_valid || out_ready);

  assign cmd_hs    = cmd_valid && cmd_ready;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_elem = (count == len_q - LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_hs) begin
          state_nxt = (cmd_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_hs && last_elem) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (out_hs && out_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      bypass_q  <= 1'b0;
      count     <= '0;
      neg_count <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (cmd_hs) begin
        len_q     <= cmd_len;
        bypass_q  <= cmd_bypass;
        count     <= '0;
        neg_count <= '0;
      end

      if (in_hs) begin
        out_data  <= (bypass_q || !in_data[WIDTH-1]) ? in_data : '0;
        out_valid <= 1'b1;
        out_last  <= last_elem;
        count     <= count + LEN_W'(1);
        // Negative inputs are counted even when the data is bypassed.
        if (in_data[WIDTH-1]) begin
          neg_count <= neg_count + LEN_W'(1);
        end
      end else if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// tb/tb_relu_stream_ctrl.sv - self-checking bench for relu_stream_ctrl
// Queue-based model checked every negedge, plus literal per-vector expectations.
module tb_relu_stream_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_len;
  logic        cmd_bypass;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [9:0]  neg_count;

  relu_stream_ctrl #(.WIDTH(16), .LEN_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_bypass(cmd_bypass),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .neg_count(neg_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] got_d[$];
  logic        got_l[$];
  bit          vec_open = 0;
  bit          done_due = 0;
  int          m_len = 0;
  int          m_idx = 0;
  int          m_neg = 0;
  bit          m_byp = 0;
  int          n_done = 0;
  bit          held_v = 0;
  logic [15:0] held_d = '0;
  logic        held_l = 1'b0;

  // Model state reflects handshakes seen at earlier negedges, so compare first, then update.
  always @(negedge clk) begin
    bit    nd;
    beat_t e;
    if (!rst_n) begin
      exp_q.delete();
      vec_open = 0;
      done_due = 0;
      m_neg    = 0;
      held_v   = 0;
    end else begin
      check("done", done, done_due);
      check("busy", busy, vec_open);
      check("cmd_ready", cmd_ready, !vec_open);
      check("neg_count", neg_count, m_neg);
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
      if (held_v) begin
        check("hold_data", out_data, held_d);
        check("hold_last", out_last, held_l);
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;

      nd = 0;
      if (done) n_done++;
      if (done_due) vec_open = 0;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        if (exp_q.size() == 0) begin
          check("unexpected_beat", out_data, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_last", out_last, e.l);
          if (e.l) nd = 1;
        end
      end
      if (cmd_valid && cmd_ready) begin
        vec_open = 1;
        m_len    = int'(cmd_len);
        m_byp    = cmd_bypass;
        m_idx    = 0;
        m_neg    = 0;
        if (cmd_len == 0) nd = 1;
      end
      if (in_valid && in_ready) begin
        e.d = (m_byp || $signed(in_data) >= 0) ? in_data : 16'h0000;
        e.l = (m_idx == m_len - 1);
        exp_q.push_back(e);
        m_idx++;
        if ($signed(in_data) < 0) m_neg++;
      end
      done_due = nd;
    end
  end

  int rmode = 0;
  int rcyc  = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rcyc++;
      out_ready = (rmode == 0) ? 1'b1 : (rcyc % 3 == 0);
    end
  end

  logic [15:0] vec [0:7];

  task automatic send_cmd(input int len, input bit byp, input bit keep);
    bit hs;
    int tries;
    @(posedge clk);
    #1;
    cmd_valid  = 1'b1;
    cmd_len    = 10'(len);
    cmd_bypass = byp;
    hs = 0;
    tries = 0;
    while (!hs && tries < 100) begin
      @(negedge clk);
      hs = cmd_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!hs) check("cmd_timeout", 0, 1);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic stream(input int n);
    bit hs;
    int tries;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i];
      hs = 0;
      tries = 0;
      while (!hs && tries < 100) begin
        @(negedge clk);
        hs = in_ready;
        @(posedge clk);
        #1;
        tries++;
      end
      if (!hs) check("in_timeout", i, 32'hFFFF);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) check("done_timeout", 0, 1);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic clear_log();
    got_d.delete();
    got_l.delete();
  endtask

  task automatic check_log(input string name, input int n, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4);
    logic [15:0] ex [0:4];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3; ex[4] = e4;
    check({name, "_beats"}, got_d.size(), n);
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      check({name, "_data"}, got_d[i], ex[i]);
      check({name, "_last"}, got_l[i], (i == n - 1));
    end
  endtask

  int d0;

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_len    = '0;
    cmd_bypass = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_neg_count", neg_count, 0);
    check("rst_out_data", out_data, 0);
    #2 rst_n = 1'b1;

    // 1: ReLU, free-flowing output
    clear_log();
    d0 = n_done;
    vec[0] = 16'h0123; vec[1] = 16'h0000; vec[2] = 16'h8123; vec[3] = 16'h7FFF;
    send_cmd(4, 0, 0);
    stream(4);
    wait_done();
    check_log("t1", 4, 16'h0123, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000);
    @(negedge clk);
    check("t1_neg_count", neg_count, 1);
    check("t1_done_pulses", n_done - d0, 1);

    // 2: bypass
    clear_log();
    vec[0] = 16'hFFFF; vec[1] = 16'h8000; vec[2] = 16'h0005;
    send_cmd(3, 1, 0);
    stream(3);
    wait_done();
    check_log("t2", 3, 16'hFFFF, 16'h8000, 16'h0005, 16'h0000, 16'h0000);
    @(negedge clk);
    check("t2_neg_count", neg_count, 2);

    // 3: output back-pressure
    clear_log();
    rmode = 1;
    vec[0] = 16'h0001; vec[1] = 16'hFFF0; vec[2] = 16'h0203; vec[3] = 16'h7FFF; vec[4] = 16'h8000;
    send_cmd(5, 0, 0);
    stream(5);
    wait_done();
    rmode = 0;
    check_log("t3", 5, 16'h0001, 16'h0000, 16'h0203, 16'h7FFF, 16'h0000);
    @(negedge clk);
    check("t3_neg_count", neg_count, 2);

    // 4: empty vector
    clear_log();
    d0 = n_done;
    send_cmd(0, 0, 0);
    wait_done();
    @(negedge clk);
    check("t4_beats", got_d.size(), 0);
    check("t4_done_pulses", n_done - d0, 1);
    check("t4_idle", busy, 0);

    // 5: command held during a vector
    clear_log();
    vec[0] = 16'h0010; vec[1] = 16'h8010; vec[2] = 16'h0020;
    send_cmd(3, 0, 1);
    cmd_len    = 10'd2;
    cmd_bypass = 1'b1;
    stream(3);
    wait_done();
    check_log("t5a", 3, 16'h0010, 16'h0000, 16'h0020, 16'h0000, 16'h0000);
    @(negedge clk);
    check("t5_cmd_ready_after_done", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    clear_log();
    vec[0] = 16'h9000; vec[1] = 16'h0042;
    stream(2);
    wait_done();
    check_log("t5b", 2, 16'h9000, 16'h0042, 16'h0000, 16'h0000, 16'h0000);

    // 6: reset mid-vector
    vec[0] = 16'h8001; vec[1] = 16'h0011;
    send_cmd(6, 0, 0);
    stream(2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_out_last", out_last, 0);
    check("t6_out_data", out_data, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_neg_count", neg_count, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    clear_log();
    d0 = n_done;
    vec[0] = 16'h1111; vec[1] = 16'hF000; vec[2] = 16'h2222;
    vec[3] = 16'h8888; vec[4] = 16'h0000; vec[5] = 16'h7FFE;
    send_cmd(6, 0, 0);
    stream(6);
    wait_done();
    check("t6_beats", got_d.size(), 6);
    @(negedge clk);
    check("t6_full_neg_count", neg_count, 2);
    check("t6_done_pulses", n_done - d0, 1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
